fp_convert_pipe: RTL and testbench
==================================

// Module: fp_convert_pipe
// PURPOSE
//  Pipelined, parametrised two's-complement to sign/exponent/mantissa converter with valid/ready handshake.
//  Successor to the 13-bit combinational linear-to-float converter; adds selectable rounding, overflow/inexact flags,
//  correct handling of the most-negative input, and a saturating overflow-event counter.
//  Sits between a sample producer and any consumer of compressed magnitudes; value = (-1)^S * F * 2^E.
// PARAMETERS
//  IN_W   13  input width (two's complement), >= MAN_W+2
//  EXP_W  3   exponent width
//  MAN_W  5   mantissa width (no hidden bit; F holds the leading one when E>0)
//  CNT_W  16  overflow-event counter width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      input sample valid
//  in_ready   out  1      block can accept a sample this cycle
//  in_data    in   IN_W   two's-complement sample
//  rnd_mode   in   2      00 half-up, 01 truncate, 10 half-even, 11 truncate; sampled with in_data
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_s      out  1      sign
//  out_e      out  EXP_W  exponent
//  out_f      out  MAN_W  mantissa
//  out_ovf    out  1      result saturated
//  out_inx    out  1      any nonzero bit discarded (rounding or saturation)
//  cnt_clr    in   1      synchronous clear of ovf_cnt
//  ovf_cnt    out  CNT_W  count of transferred results with out_ovf=1, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all stage valids 0, all out_* 0, ovf_cnt 0. Reset mid-stream drops in-flight samples.
//  Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  Pipeline: 3 stages, global enable en = ~out_valid | out_ready; in_ready = en. Latency 3 cycles when unstalled,
//  one result per cycle; order preserved, no drops or duplicates; stage contents hold while en=0.
//  out_* stable while out_valid & ~out_ready.
//  S1: S = in_data[IN_W-1]; mag = |in_data| in IN_W bits (most-negative input gives 2^(IN_W-1), no wrap); latch rnd_mode.
//  S2: p = index of leading one of mag (mag=0 -> p treated as MAN_W-1); k = max(0, p-(MAN_W-1)).
//    F0 = mag[k+MAN_W-1:k]; G = mag[k-1] (0 if k=0); T = OR of mag[k-2:0] (0 if k<2).
//  S3 rounding: inc = half-up: G; half-even: G & (T | F0[0]); truncate: 0.
//    If inc and F0 = all-ones: F = 1<<(MAN_W-1), k = k+1; else F = F0 + inc.
//    Saturate: if k > 2^EXP_W-1 then E = all-ones, F = all-ones, ovf = 1; else E = k, ovf = 0.
//    inx = G | T | ovf. Sign passes through (S=1 with F=0 impossible; mag=0 only for in_data=0).
//  Internal exponent held in EXP_W+1 bits so overflow is detected before truncation.
//  ovf_cnt: on out transfer with out_ovf=1, increment unless all-ones; cnt_clr=1 clears and wins over increment same cycle.
//  rnd_mode change between samples affects only samples transferred after the change.
// TESTING
//  in_data=0, half-up -> S=0 E=0 F=00000 ovf=0 inx=0, out_valid exactly 3 cycles after transfer.
//  in_data=422, half-up -> S=0 E=4 F=11010 inx=1 (discarded bits 0110; G=0, T=1); 126 -> E=3 F=10000 (mantissa carry).
//  in_data=45: half-up -> E=1 F=10111; half-even -> E=1 F=10110; truncate -> E=1 F=10110; all inx=1.
//  in_data=13'h1000 (-4096) -> S=1 E=111 F=11111 ovf=1; 13'h0FFF -> S=0 E=111 F=11111 ovf=1; ovf_cnt=2, then cnt_clr -> 0.
//  Stream 8 samples back-to-back with out_ready low cycles 4-8: exactly 3 held in pipe, in_ready=0 while stalled,
//  all 8 results delivered in order, outputs constant during stall.
//  Assert rst_n=0 for 1 cycle with 2 samples in flight -> no out_valid afterwards until new input; ovf_cnt=0.

Source files
------------

// File: rtl/fp_convert_pipe.sv
// -----------------------------------------------------------------------------
// fp_convert_pipe
//   Three-stage pipelined converter from a two's-complement sample to a
//   sign / exponent / mantissa triple, value = (-1)^S * F * 2^E. F carries no
//   hidden bit: when E > 0 its MSB holds the leading one of the magnitude.
//   Rounding mode is selectable per sample. Results that do not fit saturate
//   and raise out_ovf. out_inx flags any nonzero discarded bit. A saturating
//   counter tallies delivered overflow results.
//
// Ports
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; in_data, rnd_mode sampled on transfer
//   rnd_mode             00 half-up, 01 truncate, 10 half-even, 11 truncate
//   out_valid/out_ready  output handshake
//   out_s/out_e/out_f    sign, exponent, mantissa
//   out_ovf, out_inx     saturated, inexact
//   cnt_clr              synchronous clear of ovf_cnt (wins over increment)
//   ovf_cnt              delivered results with out_ovf=1, saturates at all-ones
// -----------------------------------------------------------------------------
module fp_convert_pipe #(
  parameter int IN_W  = 13,
  parameter int EXP_W = 3,
  parameter int MAN_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_f,
  output logic             out_ovf,
  output logic             out_inx,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  // The internal exponent is wide enough to hold both the largest shift plus
  // a rounding carry and one bit above the output exponent, so overflow is
  // seen before the value is truncated to EXP_W bits.
  localparam int KW_A = EXP_W + 1;
  localparam int KW_B = $clog2(IN_W) + 1;
  localparam int KW   = (KW_A > KW_B) ? KW_A : KW_B;
  localparam int E_MAX = (1 << EXP_W) - 1;

  localparam logic [IN_W-1:0]  IN_ONE  = IN_W'(1);
  localparam logic [MAN_W-1:0] F_CARRY = {1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    RND_HALF_UP   = 2'b00,
    RND_TRUNC     = 2'b01,
    RND_HALF_EVEN = 2'b10,
    RND_TRUNC_ALT = 2'b11
  } rnd_e;

  // One enable moves every stage together; a stalled output freezes the pipe.
  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- stage 1
  logic            s1_valid;
  logic            s1_s;
  logic [IN_W-1:0] s1_mag;
  rnd_e            s1_rnd;
  logic [IN_W-1:0] mag_in;

  // Read as unsigned, the negation of the most-negative input is exactly
  // 2^(IN_W-1), so no extra bit is needed.
  assign mag_in = in_data[IN_W-1] ? (~in_data + IN_ONE) : in_data;

  // NOTE: all state below uses non-blocking assignments so every stage samples
  // the previous stage's value from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_mag   <= '0;
      s1_rnd   <= RND_HALF_UP;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_s     <= in_data[IN_W-1];
      s1_mag   <= mag_in;
      s1_rnd   <= rnd_e'(rnd_mode);
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic             s2_valid;
  logic             s2_s;
  logic [KW-1:0]    s2_k;
  logic [MAN_W-1:0] s2_f0;
  logic             s2_g;
  logic             s2_t;
  rnd_e             s2_rnd;

  int               lead_p;
  int               k_int;
  logic [IN_W-1:0]  shifted;
  logic [KW-1:0]    k_n;
  logic [MAN_W-1:0] f0_n;
  logic             g_n;
  logic             t_n;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    lead_p = MAN_W - 1;             // zero magnitude behaves like a small value
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lead_p = i;
    end
    k_int   = (lead_p > MAN_W - 1) ? lead_p - (MAN_W - 1) : 0;
    shifted = s1_mag >> k_int;
    f0_n    = shifted[MAN_W-1:0];
    k_n     = KW'(k_int);
    // Guard bit is the first bit below the window, sticky is everything lower.
    g_n = 1'b0;
    t_n = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (i == k_int - 1) g_n = s1_mag[i];
      if (i <  k_int - 1) t_n = t_n | s1_mag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_s     <= 1'b0;
      s2_k     <= '0;
      s2_f0    <= '0;
      s2_g     <= 1'b0;
      s2_t     <= 1'b0;
      s2_rnd   <= RND_HALF_UP;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_s     <= s1_s;
      s2_k     <= k_n;
      s2_f0    <= f0_n;
      s2_g     <= g_n;
      s2_t     <= t_n;
      s2_rnd   <= s1_rnd;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic             inc;
  logic [KW-1:0]    k_r;
  logic [MAN_W-1:0] f_r;
  logic             ovf_n;
  logic [EXP_W-1:0] e_n;
  logic [MAN_W-1:0] f_n;

  always_comb begin
    unique case (s2_rnd)
      RND_HALF_UP:   inc = s2_g;
      RND_HALF_EVEN: inc = s2_g & (s2_t | s2_f0[0]);
      default:       inc = 1'b0;
    endcase
    // A carry out of an all-ones mantissa renormalises to 100..0 one
    // exponent higher.
    if (inc && (&s2_f0)) begin
      f_r = F_CARRY;
      k_r = s2_k + KW'(1);
    end else begin
      f_r = s2_f0 + MAN_W'(inc);
      k_r = s2_k;
    end
    ovf_n = (k_r > KW'(E_MAX));
    e_n   = ovf_n ? '1 : k_r[EXP_W-1:0];
    f_n   = ovf_n ? '1 : f_r;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      out_ovf   <= 1'b0;
      out_inx   <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_s     <= s2_s;
      out_e     <= e_n;
      out_f     <= f_n;
      out_ovf   <= ovf_n;
      out_inx   <= s2_g | s2_t | ovf_n;
    end
  end

  // ------------------------------------------------------- overflow counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && out_ovf && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_convert_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_convert_pipe
//   Self-checking bench for fp_convert_pipe. Directed vectors with hand-derived
//   results, a stall scenario, a mid-stream reset and a long randomized run
//   scored against an arithmetic reference model and a queue.
// -----------------------------------------------------------------------------
module tb_fp_convert_pipe;

  localparam int IN_W  = 13;
  localparam int EXP_W = 3;
  localparam int MAN_W = 5;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             ovf;
    logic             inx;
  } exp_t;

  typedef struct {
    exp_t v;
    int   cyc;
  } item_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [EXP_W-1:0] out_e;
  logic [MAN_W-1:0] out_f;
  logic             out_ovf;
  logic             out_inx;
  logic             cnt_clr;
  logic [CNT_W-1:0] ovf_cnt;

  fp_convert_pipe #(
    .IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f),
    .out_ovf(out_ovf), .out_inx(out_inx),
    .cnt_clr(cnt_clr), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     cyc      = 0;
  item_t  q[$];
  int     cnt_m    = 0;
  bit     held     = 0;
  exp_t   held_vec;
  bit     chk_lat  = 0;
  exp_t   out_vec;

  assign out_vec = {out_s, out_e, out_f, out_ovf, out_inx};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the magnitude; rounding decided by
  // comparing the discarded remainder against half an output ulp.
  function automatic exp_t model(input logic [IN_W-1:0] d, input logic [1:0] r);
    exp_t x;
    int v, mag, p, k, f0, rem, half, f;
    bit inc;
    v   = int'($signed(d));
    mag = (v < 0) ? -v : v;
    x   = '0;
    x.s = (v < 0);
    if (mag == 0) return x;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    k   = (p > MAN_W - 1) ? p - (MAN_W - 1) : 0;
    f0  = mag >> k;
    rem = mag - (f0 << k);
    inc = 0;
    if (k > 0) begin
      half = 1 << (k - 1);
      case (r)
        2'b00:   inc = (rem >= half);
        2'b10:   inc = (rem > half) || (rem == half && (f0 % 2) == 1);
        default: inc = 0;
      endcase
    end
    f = f0 + int'(inc);
    if (f == (1 << MAN_W)) begin
      f = 1 << (MAN_W - 1);
      k++;
    end
    x.ovf = (k > (1 << EXP_W) - 1);
    x.e   = x.ovf ? '1 : k[EXP_W-1:0];
    x.f   = x.ovf ? '1 : f[MAN_W-1:0];
    x.inx = (rem != 0) || x.ovf;
    return x;
  endfunction

  function automatic exp_t mk(input logic s, input int e, input int f, input logic ovf, input logic inx);
    exp_t x;
    x.s = s; x.e = e[EXP_W-1:0]; x.f = f[MAN_W-1:0]; x.ovf = ovf; x.inx = inx;
    return x;
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, then score the
  // transfers that the next rising edge will perform.
  task automatic cycle(input logic iv, input logic [IN_W-1:0] d, input logic [1:0] r,
                       input logic ordy, input logic clr, input exp_t ex, output logic took);
    item_t it;
    @(negedge clk);
    in_valid = iv; in_data = d; rnd_mode = r; out_ready = ordy; cnt_clr = clr;
    #1;
    cyc++;
    check("ovf_cnt", 32'(ovf_cnt), 32'(cnt_m));
    check("in_ready", 32'(in_ready), 32'(!out_valid || ordy));
    if (held) check("hold_stable", 32'(out_vec), 32'(held_vec));
    took = iv && in_ready;
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        it = q.pop_front();
        check("result", 32'(out_vec), 32'(it.v));
        if (chk_lat) check("latency", 32'(cyc - it.cyc), 32'd3);
        if (!clr && it.v.ovf && cnt_m != (1 << CNT_W) - 1) cnt_m++;
      end
    end
    if (clr) cnt_m = 0;
    held     = out_valid && !ordy;
    held_vec = out_vec;
    if (took) q.push_back('{v: ex, cyc: cyc});
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = '0; rnd_mode = 2'b00;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt_m = 0;
    held  = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_vec", 32'(out_vec), 32'd0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
  endtask

  task automatic send_dir(input logic [IN_W-1:0] d, input logic [1:0] r, input exp_t ex);
    logic took;
    int   n;
    cycle(1'b1, d, r, 1'b1, 1'b0, ex, took);
    check("dir_accept", 32'(took), 32'd1);
    n = 0;
    while (q.size() != 0 && n < 10) begin
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);
      n++;
    end
    if (q.size() != 0) check("dir_timeout", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [IN_W-1:0] rand_data();
    case ($urandom_range(0, 9))
      0:       return 13'h1000;
      1:       return 13'h0FFF;
      2:       return '0;
      3:       return IN_W'($urandom_range(0, 63));
      4:       return IN_W'(-$urandom_range(1, 63));
      default: return IN_W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             took;
    logic [IN_W-1:0]  d8 [8];
    logic [1:0]       r8 [8];
    int               idx, n;
    bit               pend;
    logic [IN_W-1:0]  pd;
    logic [1:0]       pr;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; rnd_mode = 2'b00;
    out_ready = 1'b0; cnt_clr = 1'b0;
    do_reset(2);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-derived results, 3-cycle latency checked.
    chk_lat = 1;
    send_dir(13'd0,    2'b00, mk(0, 0, 5'b00000, 0, 0));
    send_dir(13'd422,  2'b00, mk(0, 4, 5'b11010, 0, 1));
    send_dir(-13'sd422, 2'b00, mk(1, 4, 5'b11010, 0, 1));
    send_dir(13'd126,  2'b00, mk(0, 3, 5'b10000, 0, 1));
    send_dir(13'd45,   2'b00, mk(0, 1, 5'b10111, 0, 1));
    send_dir(13'd45,   2'b10, mk(0, 1, 5'b10110, 0, 1));
    send_dir(13'd45,   2'b01, mk(0, 1, 5'b10110, 0, 1));
    send_dir(13'd45,   2'b11, mk(0, 1, 5'b10110, 0, 1));
    send_dir(13'h1000, 2'b00, mk(1, 7, 5'b11111, 1, 1));
    send_dir(13'h0FFF, 2'b00, mk(0, 7, 5'b11111, 1, 1));
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);
    check("ovf_cnt_two", 32'(ovf_cnt), 32'd2);

    // Clear coinciding with an overflow transfer: clear wins.
    chk_lat = 0;
    cycle(1'b1, 13'h1000, 2'b00, 1'b0, 1'b0, mk(1, 7, 5'b11111, 1, 1), took);
    n = 0;
    while (!out_valid && n < 10) begin
      cycle(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, took);
      n++;
    end
    check("clr_wait_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b1, '0, took);
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);
    check("ovf_cnt_clr", 32'(ovf_cnt), 32'd0);

    // Eight back-to-back samples, consumer stalls on calls 4..8.
    for (int i = 0; i < 8; i++) begin
      d8[i] = rand_data();
      r8[i] = 2'($urandom_range(0, 3));
    end
    idx = 0;
    for (int c = 1; c <= 40 && (idx < 8 || q.size() != 0); c++) begin
      cycle(idx < 8, d8[idx < 8 ? idx : 0], r8[idx < 8 ? idx : 0],
            !(c >= 4 && c <= 8), 1'b0, model(d8[idx < 8 ? idx : 0], r8[idx < 8 ? idx : 0]), took);
      if (took) idx++;
      if (c >= 4 && c <= 8) begin
        check("stall_depth", 32'(q.size()), 32'd3);
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
    check("stall_all_sent", 32'(idx), 32'd8);
    check("stall_drained", 32'(q.size()), 32'd0);

    // Mid-stream reset with two samples in flight.
    cycle(1'b1, 13'd300, 2'b00, 1'b1, 1'b0, model(13'd300, 2'b00), took);
    cycle(1'b1, 13'h1000, 2'b00, 1'b1, 1'b0, model(13'h1000, 2'b00), took);
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random back-pressure, mode changes and clears.
    pend = 0; pd = '0; pr = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1;
        pd   = rand_data();
        pr   = 2'($urandom_range(0, 3));
      end
      cycle(pend, pd, pr, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
            model(pd, pr), took);
      if (took) pend = 0;
    end
    n = 0;
    while (q.size() != 0 && n < 50) begin
      cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);
      n++;
    end
    check("final_drain", 32'(q.size()), 32'd0);
    cycle(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, took);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
